// File: rtl/lcd1602_bus_driver.sv
// HD44780-style 16x2 bus driver: power-on wait, four-command init, then forwards
// painter bytes with one E strobe per slot and supplies the painter's slot clock.
module lcd1602_bus_driver #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned SLOT_US   = 16000,
  parameter int unsigned PWR_SLOTS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs_in,
  input  logic       rw_in,
  input  logic [7:0] data_in,
  output logic       clk_16ms,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       lcd_en
);

  localparam int unsigned S       = (CLK_FREQ / 1_000_000) * SLOT_US;
  localparam int unsigned SC_W    = $clog2(S);
  localparam int unsigned IDX_MAX = (PWR_SLOTS > 4) ? PWR_SLOTS : 4;
  localparam int unsigned IDX_W   = $clog2(IDX_MAX);

  typedef enum logic [1:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pend_q, pend_d;
  logic              lcd_en_q, lcd_en_d;
  logic              lcd_rs_q, lcd_rs_d;
  logic              lcd_rw_q, lcd_rw_d;
  logic [7:0]        lcd_data_q, lcd_data_d;
  logic              clk_16ms_q, clk_16ms_d;
  logic              init_done_q, init_done_d;
  logic              slot_end;
  logic              nop_in;
  logic [7:0]        init_cmd;

  // Function set 8-bit/2-line, display on, entry increment, clear.
  always_comb begin
    init_cmd = 8'h00;
    case (idx_q)
      IDX_W'(0): init_cmd = 8'h38;
      IDX_W'(1): init_cmd = 8'h0C;
      IDX_W'(2): init_cmd = 8'h06;
      IDX_W'(3): init_cmd = 8'h01;
      default:   init_cmd = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    lcd_en_d    = lcd_en_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_rw_d    = lcd_rw_q;
    lcd_data_d  = lcd_data_q;
    slot_end    = (sc_q == SC_W'(S - 1));
    nop_in      = !rs_in && !rw_in && (data_in == 8'h00);
    sc_d        = slot_end ? '0 : sc_q + SC_W'(1);

    case (state_q)
      ST_PWR_WAIT: begin
        if (slot_end) begin
          if (idx_q == IDX_W'(PWR_SLOTS - 1)) begin
            state_d = ST_INIT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_INIT: begin
        if (slot_end) begin
          if (idx_q == IDX_W'(3)) begin
            state_d = ST_RUN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase

    // Capture a quarter slot in so the bus settles before E rises.
    if (sc_d == SC_W'(S / 4)) begin
      if (state_q == ST_INIT) begin
        lcd_rs_d   = 1'b0;
        lcd_rw_d   = 1'b0;
        lcd_data_d = init_cmd;
        pend_d     = 1'b1;
      end else if (state_q == ST_RUN && !nop_in) begin
        lcd_rs_d   = rs_in;
        lcd_rw_d   = rw_in;
        lcd_data_d = data_in;
        pend_d     = 1'b1;
      end
    end

    if (pend_q && sc_d == SC_W'(S / 4 + 1)) begin
      lcd_en_d = 1'b1;
    end
    if (sc_d == SC_W'(3 * S / 4)) begin
      lcd_en_d = 1'b0;
      pend_d   = 1'b0;
    end

    clk_16ms_d  = (state_d == ST_RUN) && (sc_d < SC_W'(S / 2));
    init_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PWR_WAIT;
      sc_q        <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      lcd_en_q    <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_rw_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
      clk_16ms_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      lcd_en_q    <= lcd_en_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_rw_q    <= lcd_rw_d;
      lcd_data_q  <= lcd_data_d;
      clk_16ms_q  <= clk_16ms_d;
      init_done_q <= init_done_d;
    end
  end

  assign clk_16ms  = clk_16ms_q;
  assign init_done = init_done_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = lcd_rw_q;
  assign lcd_data  = lcd_data_q;
  assign lcd_en    = lcd_en_q;

endmodule

// File: tb/tb_lcd1602_bus_driver.sv
// Directed bench for lcd1602_bus_driver with S=16, PWR_SLOTS=1; a per-cycle
// expectation is derived from the cycle number and the slot's input vector.
module tb_lcd1602_bus_driver;

  logic       clk;
  logic       reset;
  logic       rs_in;
  logic       rw_in;
  logic [7:0] data_in;
  logic       clk_16ms;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
  logic       lcd_en;

  int checks;
  int failures;

  logic [7:0] cmd_v  [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  logic       rs_v   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       rw_v   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] data_v [5] = '{8'h41, 8'h00, 8'h80, 8'h00, 8'h55};

  lcd1602_bus_driver #(
    .CLK_FREQ (1_000_000),
    .SLOT_US  (16),
    .PWR_SLOTS(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rs_in    (rs_in),
    .rw_in    (rw_in),
    .data_in  (data_in),
    .clk_16ms (clk_16ms),
    .init_done(init_done),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_data (lcd_data),
    .lcd_en   (lcd_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at cycle 0 (state right after the last reset edge); slots 0..4 are
  // PWR_WAIT/INIT with deliberately noisy inputs, slot 5+ uses the vector table.
  task automatic run_sequence(input int nslots);
    logic       e_rs, e_rw, e_en, strobe;
    logic [7:0] e_data;
    int         sc, slot;
    e_rs = 1'b0; e_rw = 1'b0; e_data = 8'h00; strobe = 1'b0;
    for (int c = 0; c < nslots * 16; c++) begin
      sc   = c % 16;
      slot = c / 16;
      if (sc == 0) begin
        strobe = 1'b0;
        if (slot < 5) begin
          rs_in = 1'b1; rw_in = 1'b1; data_in = 8'hFF;
        end else begin
          rs_in = rs_v[slot-5]; rw_in = rw_v[slot-5]; data_in = data_v[slot-5];
        end
      end
      if (sc == 4) begin
        if (slot >= 1 && slot <= 4) begin
          e_rs = 1'b0; e_rw = 1'b0; e_data = cmd_v[slot-1]; strobe = 1'b1;
        end else if (slot >= 5) begin
          if (rs_v[slot-5] || rw_v[slot-5] || data_v[slot-5] != 8'h00) begin
            e_rs = rs_v[slot-5]; e_rw = rw_v[slot-5]; e_data = data_v[slot-5];
            strobe = 1'b1;
          end
        end
      end
      e_en = strobe && sc >= 5 && sc <= 11;
      check_eq($sformatf("c%0d lcd_en", c),    32'(lcd_en),    32'(e_en));
      check_eq($sformatf("c%0d lcd_rs", c),    32'(lcd_rs),    32'(e_rs));
      check_eq($sformatf("c%0d lcd_rw", c),    32'(lcd_rw),    32'(e_rw));
      check_eq($sformatf("c%0d lcd_data", c),  32'(lcd_data),  32'(e_data));
      check_eq($sformatf("c%0d clk_16ms", c),  32'(clk_16ms),  32'(slot >= 5 && sc < 8));
      check_eq($sformatf("c%0d init_done", c), 32'(init_done), 32'(slot >= 5));
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    rs_in    = 1'b0;
    rw_in    = 1'b0;
    data_in  = 8'h00;
    tick();
    tick();
    check_eq("rst lcd_en",    32'(lcd_en),    32'd0);
    check_eq("rst lcd_data",  32'(lcd_data),  32'd0);
    check_eq("rst init_done", 32'(init_done), 32'd0);
    check_eq("rst clk_16ms",  32'(clk_16ms),  32'd0);
    reset = 1'b0;

    // Init plus RUN slots: data 0x41, NOP, command 0x80, rw-only read.
    run_sequence(9);

    // Slot 9 strobes 0x55; reset lands at sc=7 with E high.
    rs_in = rs_v[4]; rw_in = rw_v[4]; data_in = data_v[4];
    for (int i = 0; i < 7; i++) tick();
    check_eq("mid lcd_en",   32'(lcd_en),   32'd1);
    check_eq("mid lcd_data", 32'(lcd_data), 32'h55);
    check_eq("mid lcd_rs",   32'(lcd_rs),   32'd1);
    reset = 1'b1;
    tick();
    check_eq("rst2 lcd_en",    32'(lcd_en),    32'd0);
    check_eq("rst2 init_done", 32'(init_done), 32'd0);
    check_eq("rst2 clk_16ms",  32'(clk_16ms),  32'd0);
    check_eq("rst2 lcd_data",  32'(lcd_data),  32'd0);
    reset = 1'b0;

    run_sequence(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
